// File: rtl/axi64_slave_mem.sv
// axi64_slave_mem: AXI4 64-bit slave backed by a word-addressed on-chip RAM.
// Read and write channels are independent FSMs, each with one burst in flight.
// Per-beat DECERR for addresses outside [BASE_ADDR, BASE_ADDR+MEM_BYTES) and
// SLVERR for WRAP/reserved bursts or size > 3; bresp is the worst beat response.
// Optional macro AXI_SLV_RANDOM_STALL_EN adds LFSR-driven stalls on the
// handshake outputs; the default build (macro undefined) has no stall logic.
module axi64_slave_mem #(
  parameter int          ID_WIDTH  = 13,
  parameter int          MEM_BYTES = 65536,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  input  logic [31:0]         s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic [3:0]          s_axi_arcache,
  input  logic [ID_WIDTH-1:0] s_axi_arid,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [63:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic [ID_WIDTH-1:0] s_axi_rid,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [31:0]         s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic [3:0]          s_axi_awcache,
  input  logic [ID_WIDTH-1:0] s_axi_awid,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  input  logic [63:0]         s_axi_wdata,
  input  logic [7:0]          s_axi_wstrb,
  input  logic                s_axi_wlast,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  output logic [1:0]          s_axi_bresp,
  output logic [ID_WIDTH-1:0] s_axi_bid
);
  localparam int AW    = $clog2(MEM_BYTES);
  localparam int DEPTH = MEM_BYTES / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_DATA} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;

  // Response codes are ordered so that the numerically larger one is worse.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [1:0] beat_resp(input logic [31:0] addr, input logic [2:0] size,
                                           input logic [1:0] burst);
    logic [32:0] off;
    off = {1'b0, addr - BASE_ADDR};
    if (off >= 33'(MEM_BYTES)) return RESP_DECERR;
    if ((burst != BURST_FIXED && burst != BURST_INCR) || size > 3'd3) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == BURST_INCR) ? addr + (32'd1 << size) : addr;
  endfunction

  logic [63:0]         r_mem [DEPTH];

  rd_state_e           r_rd_state;
  logic [31:0]         r_ar_addr;
  logic [7:0]          r_ar_len;
  logic [2:0]          r_ar_size;
  logic [1:0]          r_ar_burst;
  logic [7:0]          r_rd_beat;
  logic                r_arready, r_rvalid, r_rlast;
  logic [63:0]         r_rdata;
  logic [1:0]          r_rresp;
  logic [ID_WIDTH-1:0] r_rid;

  wr_state_e           r_wr_state;
  logic [31:0]         r_aw_addr;
  logic [7:0]          r_aw_len;
  logic [2:0]          r_aw_size;
  logic [1:0]          r_aw_burst;
  logic [7:0]          r_wr_beat;
  logic                r_awready, r_wready, r_bvalid;
  logic [1:0]          r_bresp, r_wr_acc;
  logic [ID_WIDTH-1:0] r_bid;

  logic w_arready, w_awready, w_wready, w_rvalid, w_bvalid;

`ifdef AXI_SLV_RANDOM_STALL_EN
  logic [15:0] r_lfsr;
  logic        r_rv_shown, r_bv_shown;
  logic        w_stall;

  // Maximal 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) driving the stall bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_lfsr <= 16'hACE1;
    else          r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_stall   = r_lfsr[0] & r_lfsr[5];
  assign w_arready = r_arready & ~w_stall;
  assign w_awready = r_awready & ~w_stall;
  assign w_wready  = r_wready & ~w_stall;
  assign w_rvalid  = r_rvalid & (~w_stall | r_rv_shown);
  assign w_bvalid  = r_bvalid & (~w_stall | r_bv_shown);

  // Remember a valid that has been shown so a later stall cannot retract it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rv_shown <= 1'b0;
      r_bv_shown <= 1'b0;
    end else begin
      r_rv_shown <= w_rvalid & ~s_axi_rready;
      r_bv_shown <= w_bvalid & ~s_axi_bready;
    end
  end
`else
  assign w_arready = r_arready;
  assign w_awready = r_awready;
  assign w_wready  = r_wready;
  assign w_rvalid  = r_rvalid;
  assign w_bvalid  = r_bvalid;
`endif

  logic [1:0]    w_rd_resp;
  logic [AW-4:0] w_rd_idx, w_wr_idx;
  logic          w_wr_hs, w_wr_last, w_ram_we;
  logic [1:0]    w_wr_addr_resp, w_wr_beat_resp;

  assign w_rd_resp      = beat_resp(r_ar_addr, r_ar_size, r_ar_burst);
  assign w_rd_idx       = r_ar_addr[AW-1:3];
  assign w_wr_idx       = r_aw_addr[AW-1:3];
  assign w_wr_hs        = (r_wr_state == WR_DATA) && s_axi_wvalid && w_wready;
  assign w_wr_last      = (r_wr_beat == r_aw_len);
  assign w_wr_addr_resp = beat_resp(r_aw_addr, r_aw_size, r_aw_burst);
  assign w_wr_beat_resp = worst(w_wr_addr_resp, (s_axi_wlast != w_wr_last) ? RESP_SLVERR : RESP_OKAY);
  assign w_ram_we       = w_wr_hs && (w_wr_addr_resp == RESP_OKAY);

  // Byte-enabled RAM write; a same-cycle read of this word still sees old data.
  // NOTE: the RAM array has no reset branch so it maps onto block/distributed RAM.
  always_ff @(posedge i_clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < 8; b++) begin
        if (s_axi_wstrb[b]) r_mem[w_wr_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // Read channel FSM: accept AR, fetch one word, present it until rready, repeat.
  // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_state <= RD_IDLE;
      r_ar_addr  <= '0;
      r_ar_len   <= '0;
      r_ar_size  <= '0;
      r_ar_burst <= '0;
      r_rd_beat  <= '0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= '0;
      r_rlast    <= 1'b0;
      r_rid      <= '0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          r_arready <= 1'b1;
          if (s_axi_arvalid && w_arready) begin
            r_ar_addr  <= s_axi_araddr;
            r_ar_len   <= s_axi_arlen;
            r_ar_size  <= s_axi_arsize;
            r_ar_burst <= s_axi_arburst;
            r_rid      <= s_axi_arid;
            r_rd_beat  <= '0;
            r_arready  <= 1'b0;
            r_rd_state <= RD_FETCH;
          end
        end
        RD_FETCH: begin
          r_rdata    <= (w_rd_resp == RESP_OKAY) ? r_mem[w_rd_idx] : '0;
          r_rresp    <= w_rd_resp;
          r_rlast    <= (r_rd_beat == r_ar_len);
          r_rvalid   <= 1'b1;
          r_rd_state <= RD_DATA;
        end
        RD_DATA: begin
          if (w_rvalid && s_axi_rready) begin
            r_rvalid <= 1'b0;
            if (r_rlast) begin
              r_arready  <= 1'b1;
              r_rd_state <= RD_IDLE;
            end else begin
              r_ar_addr  <= next_addr(r_ar_addr, r_ar_size, r_ar_burst);
              r_rd_beat  <= r_rd_beat + 8'd1;
              r_rd_state <= RD_FETCH;
            end
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  // Write channel FSM: accept AW, consume len+1 W beats, then hold the B response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_state <= WR_IDLE;
      r_aw_addr  <= '0;
      r_aw_len   <= '0;
      r_aw_size  <= '0;
      r_aw_burst <= '0;
      r_wr_beat  <= '0;
      r_wr_acc   <= RESP_OKAY;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= '0;
      r_bid      <= '0;
    end else begin
      case (r_wr_state)
        WR_IDLE: begin
          r_awready <= 1'b1;
          if (s_axi_awvalid && w_awready) begin
            r_aw_addr  <= s_axi_awaddr;
            r_aw_len   <= s_axi_awlen;
            r_aw_size  <= s_axi_awsize;
            r_aw_burst <= s_axi_awburst;
            r_bid      <= s_axi_awid;
            r_wr_beat  <= '0;
            r_wr_acc   <= RESP_OKAY;
            r_awready  <= 1'b0;
            r_wready   <= 1'b1;
            r_wr_state <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_wr_hs) begin
            r_aw_addr <= next_addr(r_aw_addr, r_aw_size, r_aw_burst);
            r_wr_beat <= r_wr_beat + 8'd1;
            r_wr_acc  <= worst(r_wr_acc, w_wr_beat_resp);
            if (w_wr_last) begin
              r_wready   <= 1'b0;
              r_bvalid   <= 1'b1;
              r_bresp    <= worst(r_wr_acc, w_wr_beat_resp);
              r_wr_state <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (w_bvalid && s_axi_bready) begin
            r_bvalid   <= 1'b0;
            r_awready  <= 1'b1;
            r_wr_state <= WR_IDLE;
          end
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  // Cache hints carry no meaning for this RAM.
  logic w_unused;
  assign w_unused = ^{s_axi_arcache, s_axi_awcache};

  assign s_axi_arready = w_arready;
  assign s_axi_awready = w_awready;
  assign s_axi_wready  = w_wready;
  assign s_axi_rvalid  = w_rvalid;
  assign s_axi_bvalid  = w_bvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rid     = r_rid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bid     = r_bid;
endmodule

// File: tb/tb_axi64_slave_mem.sv
// Directed testbench for axi64_slave_mem: a table of single-beat vectors plus
// hand-written burst, error, backpressure/concurrency and reset sequences.
module tb_axi64_slave_mem;
  localparam int ID_W = 13;
  localparam int TO   = 200;
  localparam int SEL_AR = 0, SEL_AW = 1, SEL_W = 2, SEL_R = 3, SEL_B = 4;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

  logic            i_clk = 1'b0, i_rst_n = 1'b0;
  logic            s_axi_arvalid = 0, s_axi_arready;
  logic [31:0]     s_axi_araddr = '0;
  logic [7:0]      s_axi_arlen = '0;
  logic [2:0]      s_axi_arsize = '0;
  logic [1:0]      s_axi_arburst = '0;
  logic [3:0]      s_axi_arcache = '0;
  logic [ID_W-1:0] s_axi_arid = '0;
  logic            s_axi_rvalid, s_axi_rready = 0;
  logic [63:0]     s_axi_rdata;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rlast;
  logic [ID_W-1:0] s_axi_rid;
  logic            s_axi_awvalid = 0, s_axi_awready;
  logic [31:0]     s_axi_awaddr = '0;
  logic [7:0]      s_axi_awlen = '0;
  logic [2:0]      s_axi_awsize = '0;
  logic [1:0]      s_axi_awburst = '0;
  logic [3:0]      s_axi_awcache = '0;
  logic [ID_W-1:0] s_axi_awid = '0;
  logic            s_axi_wvalid = 0, s_axi_wready;
  logic [63:0]     s_axi_wdata = '0;
  logic [7:0]      s_axi_wstrb = '0;
  logic            s_axi_wlast = 0;
  logic            s_axi_bvalid, s_axi_bready = 0;
  logic [1:0]      s_axi_bresp;
  logic [ID_W-1:0] s_axi_bid;

  axi64_slave_mem #(.ID_WIDTH(ID_W), .MEM_BYTES(65536), .BASE_ADDR(32'h0)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arcache(s_axi_arcache), .s_axi_arid(s_axi_arid),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rid(s_axi_rid),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awcache(s_axi_awcache), .s_axi_awid(s_axi_awid),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bid(s_axi_bid)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0]     wbuf [16];
  logic [7:0]      sbuf [16];
  logic [63:0]     rd_data [16];
  logic [1:0]      rd_resp [16];
  logic            rd_last [16];
  logic [ID_W-1:0] rd_id [16];
  logic [1:0]      wr_bresp;
  logic [ID_W-1:0] wr_bid;
  logic [63:0]     exp_w [4];

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [1:0]  exp_resp;
    logic [63:0] exp_rdata;
  } vec_t;
  localparam int NV = 22;
  vec_t vt [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit sel_val(input int sel);
    case (sel)
      SEL_AR:  return s_axi_arready;
      SEL_AW:  return s_axi_awready;
      SEL_W:   return s_axi_wready;
      SEL_R:   return s_axi_rvalid;
      default: return s_axi_bvalid;
    endcase
  endfunction

  // Wait (bounded) until the selected ready/valid is high, sampled 1 time unit after an edge.
  task automatic wait_for(input int sel, input string what);
    int i = 0;
    while (!sel_val(sel) && i < TO) begin
      @(posedge i_clk); #1;
      i++;
    end
    if (!sel_val(sel)) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout_%s: no handshake after %0d cycles, required within %0d", what, i, TO);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [ID_W-1:0] id, input int last_beat);
    s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size;
    s_axi_awburst = burst; s_axi_awid = id; s_axi_awvalid = 1'b1;
    wait_for(SEL_AW, "aw");
    @(posedge i_clk); #1;
    s_axi_awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = wbuf[b]; s_axi_wstrb = sbuf[b];
      s_axi_wlast = (b == last_beat);
      wait_for(SEL_W, "w");
      @(posedge i_clk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    s_axi_bready = 1'b1;
    wait_for(SEL_B, "b");
    wr_bresp = s_axi_bresp; wr_bid = s_axi_bid;
    @(posedge i_clk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [ID_W-1:0] id);
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = size;
    s_axi_arburst = burst; s_axi_arid = id; s_axi_arvalid = 1'b1;
    wait_for(SEL_AR, "ar");
    @(posedge i_clk); #1;
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      wait_for(SEL_R, "r");
      rd_data[b] = s_axi_rdata; rd_resp[b] = s_axi_rresp;
      rd_last[b] = s_axi_rlast; rd_id[b] = s_axi_rid;
      @(posedge i_clk); #1;
    end
    s_axi_rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, required to finish earlier");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1, 32'h200,       3'd3, INCR,  64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, OKAY,   64'h0};
    vt[1]  = '{1, 32'h200,       3'd3, INCR,  64'h0,                   8'h0F, OKAY,   64'h0};
    vt[2]  = '{0, 32'h200,       3'd3, INCR,  64'h0,                   8'h00, OKAY,   64'hFFFF_FFFF_0000_0000};
    vt[3]  = '{1, 32'h300,       3'd3, INCR,  64'h0123_4567_89AB_CDEF, 8'hFF, OKAY,   64'h0};
    vt[4]  = '{0, 32'h304,       3'd2, INCR,  64'h0,                   8'h00, OKAY,   64'h0123_4567_89AB_CDEF};
    vt[5]  = '{1, 32'h308,       3'd3, INCR,  64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, OKAY,   64'h0};
    vt[6]  = '{1, 32'h308,       3'd3, WRAP,  64'h1111_1111_1111_1111, 8'hFF, SLVERR, 64'h0};
    vt[7]  = '{0, 32'h308,       3'd3, INCR,  64'h0,                   8'h00, OKAY,   64'hAAAA_BBBB_CCCC_DDDD};
    vt[8]  = '{0, 32'h308,       3'd3, FIXED, 64'h0,                   8'h00, OKAY,   64'hAAAA_BBBB_CCCC_DDDD};
    vt[9]  = '{0, 32'h308,       3'd3, RSVD,  64'h0,                   8'h00, SLVERR, 64'h0};
    vt[10] = '{0, 32'h308,       3'd4, INCR,  64'h0,                   8'h00, SLVERR, 64'h0};
    vt[11] = '{1, 32'h308,       3'd4, INCR,  64'h5555_5555_5555_5555, 8'hFF, SLVERR, 64'h0};
    vt[12] = '{0, 32'h308,       3'd3, INCR,  64'h0,                   8'h00, OKAY,   64'hAAAA_BBBB_CCCC_DDDD};
    vt[13] = '{1, 32'h0001_0000, 3'd3, INCR,  64'h7777_7777_7777_7777, 8'hFF, DECERR, 64'h0};
    vt[14] = '{0, 32'h0001_0000, 3'd3, INCR,  64'h0,                   8'h00, DECERR, 64'h0};
    vt[15] = '{0, 32'hFFFF_FFF8, 3'd3, INCR,  64'h0,                   8'h00, DECERR, 64'h0};
    vt[16] = '{1, 32'hFFF8,      3'd3, INCR,  64'h0F0E_0D0C_0B0A_0908, 8'hFF, OKAY,   64'h0};
    vt[17] = '{0, 32'hFFF8,      3'd3, INCR,  64'h0,                   8'h00, OKAY,   64'h0F0E_0D0C_0B0A_0908};
    vt[18] = '{1, 32'h300,       3'd3, INCR,  64'h0,                   8'h00, OKAY,   64'h0};
    vt[19] = '{0, 32'h300,       3'd3, INCR,  64'h0,                   8'h00, OKAY,   64'h0123_4567_89AB_CDEF};
    vt[20] = '{1, 32'h300,       3'd3, INCR,  64'hAA00_0000_0000_00BB, 8'h81, OKAY,   64'h0};
    vt[21] = '{0, 32'h300,       3'd3, INCR,  64'h0,                   8'h00, OKAY,   64'hAA23_4567_89AB_CDBB};
    for (int i = 0; i < 16; i++) sbuf[i] = 8'hFF;

    // Reset state, sampled while reset is held across a rising edge.
    #12;
    check("reset_handshakes", {s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid}, 0);
    check("reset_rchan", {s_axi_rdata, s_axi_rresp, s_axi_rlast}, 0);
    check("reset_ids", {s_axi_rid, s_axi_bid, s_axi_bresp}, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // W beats offered before AW must wait.
    s_axi_wvalid = 1'b1;
    repeat (3) begin
      @(posedge i_clk); #1;
      check("w_before_aw_wready", s_axi_wready, 0);
    end
    s_axi_wvalid = 1'b0;

    // Single-beat vector table.
    for (int i = 0; i < NV; i++) begin
      if (vt[i].is_wr) begin
        wbuf[0] = vt[i].wdata; sbuf[0] = vt[i].wstrb;
        axi_write(vt[i].addr, 8'd0, vt[i].size, vt[i].burst, ID_W'(i + 1), 0);
        check($sformatf("v%0d_bresp", i), wr_bresp, vt[i].exp_resp);
        check($sformatf("v%0d_bid", i), wr_bid, ID_W'(i + 1));
      end else begin
        axi_read(vt[i].addr, 8'd0, vt[i].size, vt[i].burst, ID_W'(i + 1));
        check($sformatf("v%0d_rresp", i), rd_resp[0], vt[i].exp_resp);
        check($sformatf("v%0d_rdata", i), rd_data[0], vt[i].exp_rdata);
        check($sformatf("v%0d_rlast_rid", i), {rd_last[0], rd_id[0]}, {1'b1, ID_W'(i + 1)});
      end
    end
    sbuf[0] = 8'hFF;

    // INCR write then read of four words.
    exp_w = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    for (int b = 0; b < 4; b++) wbuf[b] = exp_w[b];
    axi_write(32'h100, 8'd3, 3'd3, INCR, 13'h0A5, 3);
    check("incr_bresp", wr_bresp, OKAY);
    check("incr_bid", wr_bid, 13'h0A5);
    axi_read(32'h100, 8'd3, 3'd3, INCR, 13'h1ABC);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("incr_rdata%0d", b), rd_data[b], exp_w[b]);
      check($sformatf("incr_resp_last_id%0d", b), {rd_resp[b], rd_last[b], rd_id[b]},
            {OKAY, (b == 3), 13'h1ABC});
    end

    // Narrow INCR read: 4-byte steps hit each word twice.
    axi_read(32'h100, 8'd3, 3'd2, INCR, 13'h002);
    check("narrow_rdata0", rd_data[0], exp_w[0]);
    check("narrow_rdata1", rd_data[1], exp_w[0]);
    check("narrow_rdata2", rd_data[2], exp_w[1]);
    check("narrow_rdata3", rd_data[3], exp_w[1]);

    // FIXED write burst: every beat lands on the same word, last one wins.
    wbuf[0] = 64'h5050_5050_5050_5050; wbuf[1] = 64'h5151_5151_5151_5151; wbuf[2] = 64'h5252_5252_5252_5252;
    axi_write(32'h500, 8'd2, 3'd3, FIXED, 13'h003, 2);
    check("fixed_bresp", wr_bresp, OKAY);
    axi_read(32'h500, 8'd0, 3'd3, INCR, 13'h004);
    check("fixed_rdata", rd_data[0], 64'h5252_5252_5252_5252);

    // Out-of-range two-beat read.
    axi_read(32'h0001_0000, 8'd1, 3'd3, INCR, 13'h005);
    for (int b = 0; b < 2; b++)
      check($sformatf("oor_beat%0d", b), {rd_resp[b], rd_last[b], rd_data[b]}, {DECERR, (b == 1), 64'h0});

    // WRAP write burst: SLVERR, RAM untouched.
    wbuf[0] = 64'hDEAD_DEAD_DEAD_DEAD; wbuf[1] = 64'hBEEF_BEEF_BEEF_BEEF;
    axi_write(32'h100, 8'd1, 3'd3, WRAP, 13'h006, 1);
    check("wrap_bresp", wr_bresp, SLVERR);
    axi_read(32'h100, 8'd0, 3'd3, INCR, 13'h007);
    check("wrap_ram_unchanged", rd_data[0], exp_w[0]);

    // Early wlast on beat 0 of a two-beat write: SLVERR but data still written.
    wbuf[0] = 64'h4040_4040_4040_4040; wbuf[1] = 64'h4141_4141_4141_4141;
    axi_write(32'h400, 8'd1, 3'd3, INCR, 13'h008, 0);
    check("early_wlast_bresp", wr_bresp, SLVERR);
    axi_read(32'h400, 8'd1, 3'd3, INCR, 13'h009);
    check("early_wlast_data0", rd_data[0], 64'h4040_4040_4040_4040);
    check("early_wlast_data1", rd_data[1], 64'h4141_4141_4141_4141);

    // Burst crossing the top of memory: worst response is DECERR.
    wbuf[0] = 64'h7070_7070_7070_7070; wbuf[1] = 64'h7171_7171_7171_7171;
    axi_write(32'hFFF8, 8'd1, 3'd3, INCR, 13'h00A, 1);
    check("cross_bresp", wr_bresp, DECERR);
    axi_read(32'hFFF8, 8'd1, 3'd3, INCR, 13'h00B);
    check("cross_beat0", {rd_resp[0], rd_data[0]}, {OKAY, 64'h7070_7070_7070_7070});
    check("cross_beat1", {rd_resp[1], rd_last[1], rd_data[1]}, {DECERR, 1'b1, 64'h0});

    // Read backpressure with a concurrent write burst.
    for (int b = 0; b < 4; b++) wbuf[b] = 64'h6060_6060_6060_6060 + 64'(b);
    fork
      begin
        s_axi_araddr = 32'h100; s_axi_arlen = 8'd3; s_axi_arsize = 3'd3;
        s_axi_arburst = INCR; s_axi_arid = 13'h0F0; s_axi_arvalid = 1'b1;
        wait_for(SEL_AR, "bp_ar");
        @(posedge i_clk); #1;
        s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        wait_for(SEL_R, "bp_r0");
        check("bp_beat0", s_axi_rdata, exp_w[0]);
        @(posedge i_clk); #1;
        s_axi_rready = 1'b0;
        wait_for(SEL_R, "bp_r1");
        for (int k = 0; k < 5; k++) begin
          check($sformatf("bp_hold%0d", k), {s_axi_rvalid, s_axi_rlast, s_axi_rid, s_axi_rdata},
                {1'b1, 1'b0, 13'h0F0, exp_w[1]});
          @(posedge i_clk); #1;
        end
        s_axi_rready = 1'b1;
        @(posedge i_clk); #1;
        wait_for(SEL_R, "bp_r2");
        check("bp_beat2", {s_axi_rlast, s_axi_rdata}, {1'b0, exp_w[2]});
        @(posedge i_clk); #1;
        wait_for(SEL_R, "bp_r3");
        check("bp_beat3", {s_axi_rlast, s_axi_rdata}, {1'b1, exp_w[3]});
        @(posedge i_clk); #1;
        s_axi_rready = 1'b0;
      end
      begin
        axi_write(32'h600, 8'd3, 3'd3, INCR, 13'h0F1, 3);
        check("conc_bresp_bid", {wr_bresp, wr_bid}, {OKAY, 13'h0F1});
      end
    join
    axi_read(32'h600, 8'd3, 3'd3, INCR, 13'h0F2);
    for (int b = 0; b < 4; b++)
      check($sformatf("conc_rdata%0d", b), rd_data[b], 64'h6060_6060_6060_6060 + 64'(b));

    // Reset in the middle of a read burst, while beat 1 is presented.
    s_axi_araddr = 32'h100; s_axi_arlen = 8'd3; s_axi_arsize = 3'd3;
    s_axi_arburst = INCR; s_axi_arid = 13'h077; s_axi_arvalid = 1'b1;
    wait_for(SEL_AR, "rst_ar");
    @(posedge i_clk); #1;
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    wait_for(SEL_R, "rst_r0");
    @(posedge i_clk); #1;
    s_axi_rready = 1'b0;
    wait_for(SEL_R, "rst_r1");
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_rvalid", s_axi_rvalid, 0);
    check("rst_mid_rchan", {s_axi_rdata, s_axi_rlast, s_axi_rid, s_axi_arready}, 0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    s_axi_araddr = 32'h100; s_axi_arlen = 8'd0; s_axi_arid = 13'h123; s_axi_arvalid = 1'b1;
    wait_for(SEL_AR, "post_rst_ar");
    @(posedge i_clk); #1;
    s_axi_arvalid = 1'b0;
    check("latency_cycle1_rvalid", s_axi_rvalid, 0);
    @(posedge i_clk); #1;
    check("latency_cycle2_rvalid", s_axi_rvalid, 1);
    check("post_rst_beat", {s_axi_rresp, s_axi_rlast, s_axi_rid, s_axi_rdata}, {OKAY, 1'b1, 13'h123, exp_w[0]});
    s_axi_rready = 1'b1;
    @(posedge i_clk); #1;
    s_axi_rready = 1'b0;
    check("post_rst_rvalid_drop", s_axi_rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
